// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetches 64-bit instruction words from instruction memory into a 2-entry
//   in-order FIFO of {word, pc}. One memory request may be outstanding at a
//   time. A redirect restarts fetch at a new 8-byte-aligned address. Any
//   response still in flight at that point is discarded through a drop flag.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          synchronous active-low reset
//   mem_req        fetch request to instruction memory
//   mem_addr       fetch byte address, valid while mem_req=1
//   mem_ack        request accepted this cycle (mem_req & mem_ack)
//   mem_rvalid     read data returned this cycle
//   mem_rdata      returned instruction word
//   redirect       restart fetch at redirect_addr
//   redirect_addr  new fetch address, bits [2:0] ignored
//   instr_out      FIFO head word
//   instr_pc       FIFO head address
//   instr_valid    FIFO non-empty
//   instr_ready    consumer takes the head when instr_valid & instr_ready
// -----------------------------------------------------------------------------
// state  | meaning
// S_REQ  | may issue a request at r_pc when the FIFO has room; while r_drop is
//        | set, the FSM waits for the discarded response and issues nothing
// S_WAIT | one request outstanding; its response is pushed on mem_rvalid
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [63:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_drop;
    logic              w_drop_nxt;
    logic              r_hold;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;

    logic [63:0]       r_word [2];
    logic [ADDR_W-1:0] r_wpc  [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_pending;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    // Low address bits of a redirect target are forced to zero.
    assign w_unused = ^redirect_addr[2:0];

    // r_hold keeps mem_req low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_hold  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        mem_req     = 1'b0;
        mem_addr    = r_pc;

        // The occupancy used here is the registered value, so a request is
        // only made when there is guaranteed room for its response.
        if (rst_n && !r_hold && !r_drop && (r_state == S_REQ) && (r_count < 2'd2))
            mem_req = 1'b1;

        w_accept = mem_req & mem_ack;

        // A response is still owed after this edge if a request is accepted
        // now, or one was already in flight and does not return this cycle.
        w_pending = w_accept | (((r_state == S_WAIT) | r_drop) & ~mem_rvalid);

        if (redirect) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = w_pending;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (r_drop) begin
                        if (mem_rvalid)
                            w_drop_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid)
                        w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    assign w_push = (r_state == S_WAIT) & mem_rvalid & ~redirect;
    assign w_pop  = instr_valid & instr_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else if (redirect) begin
            r_pc     <= {redirect_addr[ADDR_W-1:3], 3'b000};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_req_addr <= r_pc;
                r_pc       <= r_pc + ADDR_W'(8);
            end
            if (w_push) begin
                r_word[r_wr_ptr] <= mem_rdata;
                r_wpc[r_wr_ptr]  <= r_req_addr;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head outputs read as zero while the FIFO is empty.
    always_comb begin
        instr_valid = rst_n & (r_count != 2'd0);
        instr_out   = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            instr_out = r_word[r_rd_ptr];
            instr_pc  = r_wpc[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Randomized bench for instruction_fetch. A transaction-level reference
//   model (expected fetch address, queue of expected {word, pc}, one
//   outstanding-response record) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int unsigned       ADDR_W   = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    logic              clk;
    logic              rst_n;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [63:0]       instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    instruction_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0]       w;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    // reference model state
    ent_t              m_q[$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_out;
    bit                m_drop;
    logic [ADDR_W-1:0] m_addr;
    bit                m_hold;

    // stimulus control
    int  p_ack, p_rv, p_rdy, p_redir, p_stray, p_rst;
    int  rst_cnt;
    bit  stray_now;
    bit  force_fff8;
    bit  dir35;

    int  n_checks;
    int  n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    task automatic set_probs(input int ack, input int rv, input int rdy,
                             input int redir, input int stray, input int rst);
        p_ack = ack; p_rv = rv; p_rdy = rdy;
        p_redir = redir; p_stray = stray; p_rst = rst;
    endtask

    task automatic drive_inputs();
        if (rst_cnt == 0 && m_out && pct(p_rst))
            rst_cnt = $urandom_range(3, 1);
        rst_n       = (rst_cnt == 0);
        mem_ack     = pct(p_ack);
        mem_rdata   = {$urandom(), $urandom()};
        instr_ready = pct(p_rdy);
        if (!rst_n)
            mem_rvalid = 1'b0;
        else if (m_out)
            mem_rvalid = pct(p_rv);
        else
            mem_rvalid = stray_now || pct(p_stray);
        stray_now = 0;
        redirect  = pct(p_redir);
        if ($urandom_range(3, 0) == 0)
            redirect_addr = {13'h1FFF, 3'($urandom_range(7, 0))};
        else
            redirect_addr = 16'($urandom_range(16'hFFFF, 0));
        if (force_fff8) begin
            redirect      = 1'b1;
            redirect_addr = 16'hFFFB;
            force_fff8    = 0;
        end
        if (dir35 && m_out && m_addr == 16'h0010) begin
            redirect      = 1'b1;
            redirect_addr = 16'h0104;
            mem_rvalid    = 1'b0;
            dir35         = 0;
        end
    endtask

    task automatic check_and_update();
        bit   exp_req;
        bit   exp_v;
        bit   accept;
        ent_t e;

        exp_req = rst_n && !m_hold && !m_out && (m_q.size() < 2);
        exp_v   = rst_n && (m_q.size() != 0);

        chk("mem_req", 64'(mem_req), 64'(exp_req));
        if (exp_req)
            chk("mem_addr", 64'(mem_addr), 64'(m_pc));
        chk("instr_valid", 64'(instr_valid), 64'(exp_v));
        if (exp_v) begin
            chk("instr_out", instr_out, m_q[0].w);
            chk("instr_pc", 64'(instr_pc), 64'(m_q[0].pc));
        end else begin
            chk("instr_out_idle", instr_out, 64'd0);
            chk("instr_pc_idle", 64'(instr_pc), 64'd0);
        end

        accept = exp_req && mem_ack;

        if (!rst_n) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_out  = 0;
            m_drop = 0;
            m_hold = 1;
            rst_cnt--;
            if (rst_cnt == 0)
                stray_now = 1;
        end else begin
            m_hold = 0;
            if (redirect) begin
                m_q.delete();
                m_pc = {redirect_addr[ADDR_W-1:3], 3'b000};
                if (accept) begin
                    m_out  = 1;
                    m_drop = 1;
                end else if (m_out && mem_rvalid) begin
                    m_out  = 0;
                    m_drop = 0;
                end else if (m_out) begin
                    m_drop = 1;
                end
            end else begin
                if (exp_v && instr_ready)
                    void'(m_q.pop_front());
                if (m_out && mem_rvalid) begin
                    if (!m_drop) begin
                        e.w  = mem_rdata;
                        e.pc = m_addr;
                        m_q.push_back(e);
                    end
                    m_out  = 0;
                    m_drop = 0;
                end
                if (accept) begin
                    m_out  = 1;
                    m_drop = 0;
                    m_addr = m_pc;
                    m_pc   = m_pc + 16'd8;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            #4;
            check_and_update();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        rst_n = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
        m_pc = RESET_PC; m_out = 0; m_drop = 0; m_addr = '0; m_hold = 1;
        stray_now = 0; force_fff8 = 0; dir35 = 0;
        set_probs(0, 0, 0, 0, 0, 0);
        rst_cnt = 0;
        @(posedge clk);
        #1;

        // streaming: ack and response one cycle after each request
        set_probs(100, 100, 100, 0, 0, 0);
        rst_cnt = 2;
        run(40);

        // stalled consumer fills the FIFO, then drains and resumes
        set_probs(100, 100, 0, 0, 0, 0);
        rst_cnt = 1;
        run(30);
        p_rdy = 100;
        run(20);

        // redirect to 0x0104 while waiting on 0x0010
        set_probs(100, 100, 100, 0, 0, 0);
        rst_cnt = 1;
        dir35   = 1;
        run(30);

        // redirect to the top of the address space, fetch wraps to 0
        force_fff8 = 1;
        run(30);

        // reset while waiting; late response must be ignored
        set_probs(100, 0, 100, 0, 0, 100);
        run(12);
        set_probs(100, 100, 100, 0, 0, 0);
        run(20);

        // random traffic
        set_probs(60, 40, 50, 3, 10, 1);
        run(3000);
        set_probs(80, 70, 30, 5, 10, 2);
        run(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
